// File: rtl/axis_str_fifo.sv
// ---------------------------------------------------------------------------
// axis_str_fifo
//   Single-clock AXI4-Stream FIFO. Buffers up to 2^ADDR_WDTH words from the
//   slave port and replays them in order, first-word-fall-through, on the
//   master port.
//
// Ports
//   axis_clk       in   clock for both stream ports
//   axis_areset    in   asynchronous active-high reset
//   s_axis_tdata   in   write data
//   s_axis_tvalid  in   write data valid
//   s_axis_tready  out  FIFO can accept a word (registered, !full)
//   m_axis_tdata   out  head-of-FIFO word, 0 when empty (registered)
//   m_axis_tvalid  out  FIFO holds at least one word (registered, !empty)
//   m_axis_tready  in   downstream accepts the head word
// ---------------------------------------------------------------------------
module axis_str_fifo #(
    parameter int unsigned ADDR_WDTH = 3,
    parameter int unsigned DATA_WDTH = 8
) (
    input  logic                 axis_clk,
    input  logic                 axis_areset,
    input  logic [DATA_WDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DATA_WDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready
);

    localparam int unsigned DEPTH = 1 << ADDR_WDTH;
    localparam int unsigned PTR_W = ADDR_WDTH + 1;

    logic [DATA_WDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic                 r_s_tready;
    logic                 r_m_tvalid;
    logic [DATA_WDTH-1:0] r_m_tdata;

    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic [ADDR_WDTH-1:0] w_wr_idx;
    logic [ADDR_WDTH-1:0] w_rd_idx_nxt;
    logic                 w_empty_nxt;
    logic                 w_full_nxt;
    logic [DATA_WDTH-1:0] w_head_nxt;

    // Handshakes are qualified by the registered ready/valid only, so there
    // is no combinational path between the two stream ports.
    assign w_wr_en = s_axis_tvalid & r_s_tready;
    assign w_rd_en = r_m_tvalid & m_axis_tready;

    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr_en);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_en);
    assign w_wr_idx     = r_wr_ptr[ADDR_WDTH-1:0];
    assign w_rd_idx_nxt = w_rd_ptr_nxt[ADDR_WDTH-1:0];

    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    assign w_full_nxt  = (w_wr_ptr_nxt[ADDR_WDTH-1:0] == w_rd_ptr_nxt[ADDR_WDTH-1:0]) &&
                         (w_wr_ptr_nxt[ADDR_WDTH] != w_rd_ptr_nxt[ADDR_WDTH]);

    // Next head word: a write landing exactly at the next read slot can only
    // happen when the FIFO is about to hold just that word, so bypass it.
    assign w_head_nxt = (w_wr_en && (w_wr_idx == w_rd_idx_nxt)) ? s_axis_tdata
                                                                 : r_mem[w_rd_idx_nxt];

    // Storage array, deliberately not reset.
    always_ff @(posedge axis_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= s_axis_tdata;
        end
    end

    // Pointers and registered stream outputs derived from next-state pointers.
    always_ff @(posedge axis_clk or posedge axis_areset) begin
        if (axis_areset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_s_tready <= !w_full_nxt;
            r_m_tvalid <= !w_empty_nxt;
            r_m_tdata  <= w_empty_nxt ? '0 : w_head_nxt;
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;

endmodule

// File: tb/tb_axis_str_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_str_fifo
//   Directed self-checking bench for axis_str_fifo: reset, fill to full,
//   overflow hold, drain, pointer-wrap refill, reset mid-stream, and a
//   queue-modelled streaming run with steady and random backpressure.
// ---------------------------------------------------------------------------
module tb_axis_str_fifo;

    localparam int unsigned ADDR_WDTH = 3;
    localparam int unsigned DATA_WDTH = 8;
    localparam int unsigned DEPTH     = 1 << ADDR_WDTH;

    logic                 axis_clk;
    logic                 axis_areset;
    logic [DATA_WDTH-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [DATA_WDTH-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;

    int checks;
    int failures;

    axis_str_fifo #(
        .ADDR_WDTH (ADDR_WDTH),
        .DATA_WDTH (DATA_WDTH)
    ) u_dut (
        .axis_clk      (axis_clk),
        .axis_areset   (axis_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] vec [8]);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = vec[i];
            step();
            check("fill_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("fill_head", 32'(m_axis_tdata), 32'(vec[0]));
            check("fill_tready", 32'(s_axis_tready), (i < 7) ? 32'd1 : 32'd0);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input logic [7:0] vec [8]);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("drain_data", 32'(m_axis_tdata), 32'(vec[i]));
            step();
            check("drain_tready", 32'(s_axis_tready), 32'd1);
        end
        check("drain_empty_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("drain_empty_tdata", 32'(m_axis_tdata), 32'd0);
        m_axis_tready = 1'b0;
    endtask

    // Streaming with a queue model; rdy_pct is the chance m_axis_tready is high.
    task automatic stream(input int n_words, input int rdy_pct, input int vld_pct,
                          input int exp_cycles);
        logic [7:0] q [$];
        logic [7:0] word;
        int         sent;
        int         cycles;
        logic       wr;
        logic       rd;
        sent   = 0;
        cycles = 0;
        word   = 8'($urandom);
        while ((sent < n_words || q.size() != 0) && cycles < 4000) begin
            s_axis_tvalid = (sent < n_words) && ($urandom_range(99) < vld_pct);
            s_axis_tdata  = word;
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            check("str_tready", 32'(s_axis_tready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
            check("str_tvalid", 32'(m_axis_tvalid), (q.size() > 0) ? 32'd1 : 32'd0);
            if (q.size() > 0) begin
                check("str_data", 32'(m_axis_tdata), 32'(q[0]));
            end
            wr = s_axis_tvalid && (q.size() < DEPTH);
            rd = (q.size() > 0) && m_axis_tready;
            step();
            cycles++;
            if (rd) void'(q.pop_front());
            if (wr) begin
                q.push_back(word);
                sent++;
                word = 8'($urandom);
            end
        end
        if (exp_cycles > 0) begin
            check("str_cycles", 32'(cycles), 32'(exp_cycles));
        end else begin
            check("str_timeout", (cycles < 4000) ? 32'd1 : 32'd0, 32'd1);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    logic [7:0] vec_a [8];
    logic [7:0] vec_b [8];

    initial begin
        checks        = 0;
        failures      = 0;
        vec_a         = '{8'hBA, 8'hDA, 8'hFA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
        vec_b         = '{8'h11, 8'hCE, 8'hCA, 8'hFE, 8'hDE, 8'h22, 8'h33, 8'h88};
        axis_areset   = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        axis_areset = 1'b0;
        check("rel_tready_pre", 32'(s_axis_tready), 32'd0);
        step();
        check("rel_tready", 32'(s_axis_tready), 32'd1);
        check("rel_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Fill, overflow hold, drain
        fill(vec_a);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h9A;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ovf_tready", 32'(s_axis_tready), 32'd0);
            check("ovf_head", 32'(m_axis_tdata), 32'hBA);
        end
        s_axis_tvalid = 1'b0;
        drain(vec_a);

        // Refill across pointer wrap
        fill(vec_b);
        drain(vec_b);

        // Asynchronous reset mid-stream discards stored words
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = vec_a[i];
            step();
        end
        s_axis_tvalid = 1'b0;
        check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        #2;
        axis_areset = 1'b1;
        #1;
        check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
        repeat (20) @(posedge axis_clk);
        #1;
        axis_areset = 1'b0;
        step();
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);
        check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h77;
        step();
        s_axis_tvalid = 1'b0;
        check("post_rst_data", 32'(m_axis_tdata), 32'h77);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("post_rst_empty", 32'(m_axis_tvalid), 32'd0);

        // Streaming: full rate, then random backpressure and gaps
        stream(101, 100, 100, 102);
        stream(101, 50, 100, 0);
        stream(101, 70, 60, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_str_fifo.md
Name: axis_str_fifo

Overview:
- Single-clock AXI4-Stream FIFO.
- Accepts bytes on a slave AXIS port and buffers up to 2^ADDR_WDTH words.
- Replays them in order on a master AXIS port.
- Sits between a byte-stream producer and a consumer that may stall for long periods, absorbing bursts of up to 8 words with default parameters.

Parameters:
- ADDR_WDTH, 3: address width; FIFO depth DEPTH = 2^ADDR_WDTH (8).
- DATA_WDTH, 8: data width of s_axis_tdata and m_axis_tdata.

Ports:
- axis_clk  input  1  single clock for both AXIS ports.
- axis_areset  input  1  reset, asynchronous and active-high.
- s_axis_tdata  input  DATA_WDTH  slave (write) data.
- s_axis_tvalid  input  1  slave data valid.
- s_axis_tready  output  1  FIFO can accept a word.
- m_axis_tdata  output  DATA_WDTH  master (read) data.
- m_axis_tvalid  output  1  FIFO holds at least one word.
- m_axis_tready  input  1  downstream accepts the word.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x DATA_WDTH register array; it is not reset.
  - Write and read pointers are ADDR_WDTH+1 bits wide. The lower ADDR_WDTH bits index the array; the MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = lower bits equal AND MSBs differ.
- Reset (axis_areset = 1, applied immediately, independent of clock):
  - wr_ptr = rd_ptr = 0.
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0.
  - After release, first rising edge: s_axis_tready = 1.
  - Reset mid-operation discards all stored words; nothing stored before reset is ever output.
- Write:
  - On a rising edge with s_axis_tvalid & s_axis_tready: mem[wr_ptr] <= s_axis_tdata and wr_ptr increments (wrapping modulo 2*DEPTH).
  - s_axis_tready = !full (registered-state based, no combinational path from m_axis_tready).
  - When full, tready is 0 and the held word is not accepted; s_axis_tvalid may stay high indefinitely.
- Read (first-word-fall-through):
  - m_axis_tvalid = !empty.
  - m_axis_tdata = mem[rd_ptr] when !empty, else 0.
  - On a rising edge with m_axis_tvalid & m_axis_tready, rd_ptr increments.
  - A word written on edge N is visible on m_axis_tdata with m_axis_tvalid = 1 after edge N (1-cycle latency).
- Simultaneous write and read on the same edge:
  - Both pointers advance and occupancy is unchanged.
  - When full, the write is blocked that cycle (tready already 0); the read frees a slot, so tready rises on the next cycle.
  - When empty, only the write occurs; the read is not possible since tvalid = 0.
- Ordering and integrity:
  - Strict FIFO order.
  - No word is duplicated or dropped.
  - Sustained throughput is 1 word/cycle when m_axis_tready stays high.
- Handshake compliance:
  - m_axis_tdata and m_axis_tvalid stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
  - m_axis_tvalid is never deasserted without a transfer (except by reset).

Test Plan:
- Reset: assert axis_areset for 20 cycles mid-stream -> s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0 immediately. After release, s_axis_tready = 1 and the FIFO is empty.
- Fill to full: with m_axis_tready = 0, write BA, DA, FA, 55, 01, 02, 03, 04 -> s_axis_tready drops to 0 after the 8th accept. m_axis_tvalid = 1 with m_axis_tdata = BA from the cycle after the first write.
- Overflow: with the FIFO full, hold s_axis_tvalid = 1 with data 9A -> not accepted, and 9A never appears on the output.
- Drain: raise m_axis_tready -> BA, DA, FA, 55, 01, 02, 03, 04 appear on 8 consecutive cycles. m_axis_tvalid then drops to 0 and s_axis_tready = 1.
- Refill with pointer wrap: write 11, CE, CA, FE, DE, 22, 33, 88 and drain -> exact same order, confirming wrap of the write and read pointers.
- Streaming: with m_axis_tready = 1, present 101 random words back-to-back -> every accepted word is output once, in order, at 1 word/cycle. Toggling m_axis_tready randomly still yields a lossless, order-preserving sequence, with s_axis_tready low exactly when occupancy is 8.
